// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control: Moore FSM sequencing fetch, decode, memory,
// ALU and branch steps, with write strobes suppressed while reset is held.
module main_control_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t cur_state;
    state_t nxt_state;

    logic ir_write_raw;
    logic reg_write_raw;
    logic mem_write_raw;
    logic illegal_raw;
    logic pc_update;
    logic branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state     = S_FETCH;
        alu_op        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        case (cur_state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_update    = 1'b1;
                nxt_state    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXECUTER;
                    OP_I:         nxt_state = S_EXECUTEI;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_JAL:       nxt_state = S_JAL;
                    default: begin
                        nxt_state   = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                nxt_state = S_ALUWB;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // Strobes are gated by reset_n directly so FETCH shows no writes while held in reset.
    assign ir_write   = ir_write_raw & reset_n;
    assign reg_write  = reg_write_raw & reset_n;
    assign mem_write  = mem_write_raw & reset_n;
    assign illegal_op = illegal_raw & reset_n;
    assign pc_write   = (pc_update | (branch & zero)) & reset_n;
    assign state      = cur_state;

endmodule
